csi_slave_protocol_layer: RTL
=============================

// Module: csi_slave_protocol_layer
// PURPOSE
//  CSI-2 receive-side protocol layer; the slave-end counterpart of the master protocol layer.
//  Consumes the HS byte stream from the D-PHY slave adapter (one lane, sync byte already stripped).
//  Parses the packet header (DI/WC/ECC) and forwards short-packet events and long-packet payload to the client.
//  Flags ECC, CRC and truncation errors. No backpressure exists anywhere in the D-PHY path.
// PARAMETERS
//  CORRECT_ECC  1        1: correct single-bit header errors; 0: flag any non-zero syndrome as ecc_err
//  CHECK_CRC    1        1: compare payload CRC16 against footer; 0: crc_err held 0
//  MAX_WC       16'hFFFF long packets with WC > MAX_WC are dropped with len_err
// PORTS
//  hs_clk         in   1   byte clock; all logic on rising edge
//  rst            in   1   synchronous, active-high reset
//  rx_active      in   1   HS burst in progress (RxActiveHS)
//  rx_valid       in   1   rx_data holds a valid byte this cycle
//  rx_data        in   8   received byte, in line order
//  hdr_valid      out  1   1-cycle pulse: header accepted; hdr_vc/hdr_dt/hdr_wc valid the same cycle
//  hdr_vc         out  2   virtual channel, DI[7:6]
//  hdr_dt         out  6   data type, DI[5:0]
//  hdr_wc         out  16  word count (short packet: 16-bit data field)
//  hdr_short      out  1   DT in 0x00..0x0F (short packet)
//  out_valid      out  1   payload byte valid
//  out_data       out  8   payload byte
//  out_sop        out  1   first payload byte of the packet
//  out_eop        out  1   last payload byte of the packet
//  pkt_done       out  1   1-cycle pulse at end of packet (after footer, or with hdr_valid for short/WC=0)
//  ecc_corrected  out  1   sticky per packet; valid with hdr_valid
//  ecc_err        out  1   uncorrectable header; 1-cycle pulse; packet discarded
//  crc_err        out  1   valid with pkt_done
//  trunc_err      out  1   1-cycle pulse: rx_active fell before the packet completed
//  len_err        out  1   1-cycle pulse: WC > MAX_WC
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; byte counter 0; CRC register 16'hFFFF.
//  A byte is accepted only when rx_active && rx_valid. Bytes with rx_active=0 are ignored.
//  FSM states:
//   IDLE -> HDR on the first accepted byte.
//   HDR: collect DI, WC_lo, WC_hi, ECC. On the 4th byte run ECC decode, then:
//    - uncorrectable -> ecc_err -> SKIP.
//    - short DT -> hdr_valid + pkt_done -> SKIP.
//    - long, WC>MAX_WC -> len_err -> SKIP.
//    - long, WC=0 -> PAYLOAD is skipped -> CRC.
//    - otherwise -> hdr_valid -> PAYLOAD.
//   PAYLOAD: emit each byte, down-count WC; on the last byte assert out_eop -> CRC.
//   CRC: collect 2 footer bytes (LS byte first); on the 2nd byte pulse pkt_done; crc_err = (calc != rx) -> SKIP.
//   SKIP: ignore bytes; -> IDLE when rx_active=0. One packet per HS burst.
//  rx_active falling in HDR, PAYLOAD or CRC: pulse trunc_err next cycle; no pkt_done; -> IDLE.
//   out_eop is not generated for the truncated packet.
//  Latency: header outputs and errors are registered 1 cycle after the 4th header byte.
//   Payload out_* are registered 1 cycle after the byte is accepted.
//  ECC: CSI-2 6-bit Hamming over 24 bits {WC_hi, WC_lo, DI}; ECC[7:6] ignored.
//   Syndrome 0 = clean. Syndrome matching a single data or parity column = correct (sets ecc_corrected).
//   Any other syndrome = ecc_err. Corrected fields drive hdr_*.
//  CRC: CRC-16/CCITT poly x^16+x^12+x^5+1, reflected (LSB first), seed 16'hFFFF, no final XOR.
//   Reset to seed at every header. Covers payload bytes only. WC=0 -> expected footer 16'hFFFF.
//  WC arithmetic is 16-bit unsigned; WC=16'hFFFF must not wrap the down-counter.
//  Idle cycles (rx_valid=0) inside a packet stall the FSM; no state change.
//  rst mid-packet: immediate return to reset state; no error pulses generated.
// STRUCTURE
//  csi_pkg (shared): DT constants (FS=0x00, FE=0x01, LS=0x02, LE=0x03, RAW8=0x2A, ...),
//   csi_pkt_hdr_t struct {vc, dt, wc}, csi_rx_state_e, function crc16_byte(), ECC parity masks.
//  Sub-module csi_ecc_decoder: combinational syndrome/correct/err. Reused by the master-side ECC generator tests.
// TESTING
//  Short FS: VC=1, DT=0x00, WC=0x0005, valid ECC -> hdr_valid, hdr_short=1, hdr_wc=5, pkt_done same cycle, no out_valid.
//  Long RAW8 packet, 24 bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, footer F0 00
//   -> 24 out_valid, sop on 1st, eop on 24th, pkt_done, crc_err=0.
//  Same packet with footer F1 00 -> crc_err=1 with pkt_done.
//  Header with WC bit 3 flipped -> ecc_corrected=1, hdr_wc correct.
//   Two bits flipped -> ecc_err, no hdr_valid, remaining burst ignored.
//  rx_active drops after 10 of 24 payload bytes -> trunc_err pulse, no eop/pkt_done; next burst decodes normally.
//  WC=0 long packet with footer FF FF -> hdr_valid, no out_valid, pkt_done, crc_err=0.
//   rx_valid gaps of 1-3 cycles inserted randomly -> identical output bytes.

Source files
------------

// File: rtl/csi_slave_protocol_layer_pkg.sv
// Shared CSI-2 receive definitions: data types, header payload struct, FSM states,
// CRC-16 byte update and the header ECC parity masks.
package csi_slave_protocol_layer_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WC_W       = 16;
  localparam int unsigned HDR_DATA_W = 24;
  localparam int unsigned ECC_W      = 6;
  localparam int unsigned CRC_W      = 16;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;
  localparam logic [5:0] DT_RAW8      = 6'h2A;

  localparam logic [CRC_W-1:0] CRC_SEED      = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC_POLY_REFL = 16'h8408;

  // Parity bit p covers the data bits set in ECC_MASK[p]; data is {WC_hi, WC_lo, DI}.
  localparam logic [ECC_W-1:0][HDR_DATA_W-1:0] ECC_MASK = {
    24'hEFFC00,
    24'hDF03F0,
    24'hB8E38E,
    24'h749A6D,
    24'hF2555B,
    24'hF12CB7
  };

  typedef struct packed {
    logic [1:0]      vc;
    logic [5:0]      dt;
    logic [WC_W-1:0] wc;
  } csi_pkt_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_SKIP
  } csi_rx_state_e;

  // Reflected CRC-16/CCITT update, one byte, LSB first.
  function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                  input logic [BYTE_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Syndrome produced by a single error on data bit k.
  function automatic logic [ECC_W-1:0] ecc_column(input logic [4:0] k);
    logic [ECC_W-1:0] col;
    col = '0;
    for (int p = 0; p < 6; p++) begin
      col[p[2:0]] = ECC_MASK[p[2:0]][k];
    end
    return col;
  endfunction

endpackage

// File: rtl/csi_slave_protocol_layer_ecc_decoder.sv
// Combinational CSI-2 header ECC decoder: syndrome, single-bit correction, uncorrectable flag.
module csi_slave_protocol_layer_ecc_decoder
  import csi_slave_protocol_layer_pkg::*;
(
  input  logic [HDR_DATA_W-1:0] data,
  input  logic [ECC_W-1:0]      ecc,
  output logic [ECC_W-1:0]      syndrome_c,
  output logic [HDR_DATA_W-1:0] data_c,
  output logic                  corrected_c,
  output logic                  err_c
);

  always_comb begin
    syndrome_c = '0;
    for (int p = 0; p < 6; p++) begin
      syndrome_c[p[2:0]] = (^(data & ECC_MASK[p[2:0]])) ^ ecc[p[2:0]];
    end
  end

  // A syndrome equal to a data column flips that bit; a one-hot syndrome is a parity-bit hit.
  always_comb begin
    data_c      = data;
    corrected_c = 1'b0;
    err_c       = 1'b0;
    if (syndrome_c != '0) begin
      err_c = 1'b1;
      for (int k = 0; k < 24; k++) begin
        if (ecc_column(k[4:0]) == syndrome_c) begin
          data_c[k[4:0]] = ~data[k[4:0]];
          corrected_c    = 1'b1;
          err_c          = 1'b0;
        end
      end
      if ($onehot(syndrome_c)) begin
        corrected_c = 1'b1;
        err_c       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/csi_slave_protocol_layer.sv
// CSI-2 receive protocol layer: parses packet headers from the D-PHY byte stream,
// forwards short events and long payload, and flags ECC/CRC/length/truncation errors.
module csi_slave_protocol_layer
  import csi_slave_protocol_layer_pkg::*;
#(
  parameter bit          CORRECT_ECC = 1'b1,
  parameter bit          CHECK_CRC   = 1'b1,
  parameter logic [15:0] MAX_WC      = 16'hFFFF
) (
  input  logic              hs_clk,
  input  logic              rst,
  input  logic              rx_active,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              hdr_valid,
  output logic [1:0]        hdr_vc,
  output logic [5:0]        hdr_dt,
  output logic [WC_W-1:0]   hdr_wc,
  output logic              hdr_short,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              pkt_done,
  output logic              ecc_corrected,
  output logic              ecc_err,
  output logic              crc_err,
  output logic              trunc_err,
  output logic              len_err
);

  csi_rx_state_e         state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [HDR_DATA_W-1:0] hdr_raw_q, hdr_raw_d;
  logic [WC_W-1:0]       wc_cnt_q, wc_cnt_d;
  logic                  sop_pend_q, sop_pend_d;
  logic [CRC_W-1:0]      crc_q, crc_d;
  logic [BYTE_W-1:0]     ftr_lo_q, ftr_lo_d;

  logic                  hdr_valid_q, hdr_valid_d;
  csi_pkt_hdr_t          hdr_out_q, hdr_out_d;
  logic                  hdr_short_q, hdr_short_d;
  logic                  out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]     out_data_q, out_data_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  ecc_corr_q, ecc_corr_d;
  logic                  ecc_err_q, ecc_err_d;
  logic                  crc_err_q, crc_err_d;
  logic                  trunc_err_q, trunc_err_d;
  logic                  len_err_q, len_err_d;

  logic [ECC_W-1:0]      dec_syndrome_c;
  logic [HDR_DATA_W-1:0] dec_data_c;
  logic                  dec_corrected_c;
  logic                  dec_err_c;
  logic [HDR_DATA_W-1:0] hdr_fix;
  logic                  hdr_bad;
  logic                  hdr_corr;
  csi_pkt_hdr_t          dec_hdr;
  logic                  acc;

  // ECC byte is decoded as it arrives, against the three bytes already collected.
  csi_slave_protocol_layer_ecc_decoder u_ecc (
    .data        (hdr_raw_q),
    .ecc         (rx_data[5:0]),
    .syndrome_c  (dec_syndrome_c),
    .data_c      (dec_data_c),
    .corrected_c (dec_corrected_c),
    .err_c       (dec_err_c)
  );

  assign acc      = rx_active && rx_valid;
  assign hdr_fix  = CORRECT_ECC ? dec_data_c : hdr_raw_q;
  assign hdr_bad  = CORRECT_ECC ? dec_err_c : (dec_syndrome_c != '0);
  assign hdr_corr = CORRECT_ECC & dec_corrected_c;
  assign dec_hdr  = '{vc: hdr_fix[7:6], dt: hdr_fix[5:0], wc: hdr_fix[23:8]};

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    hdr_raw_d   = hdr_raw_q;
    wc_cnt_d    = wc_cnt_q;
    sop_pend_d  = sop_pend_q;
    crc_d       = crc_q;
    ftr_lo_d    = ftr_lo_q;
    hdr_valid_d = 1'b0;
    hdr_out_d   = hdr_out_q;
    hdr_short_d = hdr_short_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    pkt_done_d  = 1'b0;
    ecc_corr_d  = ecc_corr_q;
    ecc_err_d   = 1'b0;
    crc_err_d   = 1'b0;
    trunc_err_d = 1'b0;
    len_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          hdr_raw_d  = {rx_data, hdr_raw_q[23:8]};
          byte_cnt_d = 2'd1;
          ecc_corr_d = 1'b0;
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        if (!rx_active) begin
          trunc_err_d = 1'b1;
          byte_cnt_d  = 2'd0;
          state_d     = ST_IDLE;
        end else if (rx_valid) begin
          if (byte_cnt_q != 2'd3) begin
            // Bytes shift in from the top so DI ends up in [7:0] after three bytes.
            hdr_raw_d  = {rx_data, hdr_raw_q[23:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end else begin
            byte_cnt_d = 2'd0;
            crc_d      = CRC_SEED;
            ecc_corr_d = hdr_corr;
            if (hdr_bad) begin
              ecc_err_d  = 1'b1;
              ecc_corr_d = 1'b0;
              state_d    = ST_SKIP;
            end else if (dec_hdr.dt <= DT_SHORT_MAX) begin
              hdr_valid_d = 1'b1;
              pkt_done_d  = 1'b1;
              hdr_out_d   = dec_hdr;
              hdr_short_d = 1'b1;
              state_d     = ST_SKIP;
            end else if ({1'b0, dec_hdr.wc} > {1'b0, MAX_WC}) begin
              len_err_d = 1'b1;
              state_d   = ST_SKIP;
            end else begin
              hdr_valid_d = 1'b1;
              hdr_out_d   = dec_hdr;
              hdr_short_d = 1'b0;
              wc_cnt_d    = dec_hdr.wc;
              sop_pend_d  = 1'b1;
              state_d     = (dec_hdr.wc == '0) ? ST_CRC : ST_PAYLOAD;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (!rx_active) begin
          trunc_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (rx_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = rx_data;
          out_sop_d   = sop_pend_q;
          sop_pend_d  = 1'b0;
          crc_d       = crc16_byte(crc_q, rx_data);
          // Counter stops at 1, so WC=FFFF never wraps.
          if (wc_cnt_q == 16'd1) begin
            out_eop_d  = 1'b1;
            byte_cnt_d = 2'd0;
            state_d    = ST_CRC;
          end else begin
            wc_cnt_d = wc_cnt_q - 16'd1;
          end
        end
      end

      ST_CRC: begin
        if (!rx_active) begin
          trunc_err_d = 1'b1;
          byte_cnt_d  = 2'd0;
          state_d     = ST_IDLE;
        end else if (rx_valid) begin
          if (byte_cnt_q == 2'd0) begin
            ftr_lo_d   = rx_data;
            byte_cnt_d = 2'd1;
          end else begin
            pkt_done_d = 1'b1;
            crc_err_d  = CHECK_CRC && ({rx_data, ftr_lo_q} != crc_q);
            byte_cnt_d = 2'd0;
            state_d    = ST_SKIP;
          end
        end
      end

      ST_SKIP: begin
        if (!rx_active) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        byte_cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge hs_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 2'd0;
      hdr_raw_q   <= '0;
      wc_cnt_q    <= '0;
      sop_pend_q  <= 1'b0;
      crc_q       <= CRC_SEED;
      ftr_lo_q    <= '0;
      hdr_valid_q <= 1'b0;
      hdr_out_q   <= '0;
      hdr_short_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      ecc_corr_q  <= 1'b0;
      ecc_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      trunc_err_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      hdr_raw_q   <= hdr_raw_d;
      wc_cnt_q    <= wc_cnt_d;
      sop_pend_q  <= sop_pend_d;
      crc_q       <= crc_d;
      ftr_lo_q    <= ftr_lo_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_out_q   <= hdr_out_d;
      hdr_short_q <= hdr_short_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_done_q  <= pkt_done_d;
      ecc_corr_q  <= ecc_corr_d;
      ecc_err_q   <= ecc_err_d;
      crc_err_q   <= crc_err_d;
      trunc_err_q <= trunc_err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign hdr_valid     = hdr_valid_q;
  assign hdr_vc        = hdr_out_q.vc;
  assign hdr_dt        = hdr_out_q.dt;
  assign hdr_wc        = hdr_out_q.wc;
  assign hdr_short     = hdr_short_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_sop       = out_sop_q;
  assign out_eop       = out_eop_q;
  assign pkt_done      = pkt_done_q;
  assign ecc_corrected = ecc_corr_q;
  assign ecc_err       = ecc_err_q;
  assign crc_err       = crc_err_q;
  assign trunc_err     = trunc_err_q;
  assign len_err       = len_err_q;

endmodule
